amm_arb2: RTL
=============

Name: amm_arb2

Overview:
- Two-master to one-slave Avalon-MM arbiter. It shares a single pipelined-read slave, such as the on-chip 16-bit word memory, between two requesters, for example the JTAG bridge master and a local test master.
- Arbitrates commands round-robin.
- Tracks outstanding reads in an ID FIFO so that each returning readdata is routed back to the master that issued the read.
- The slave must return read responses in order, with any latency of 1 or more cycles.

Parameters:
- ADDR_W, 16, address width on all three ports.
- DATA_W, 16, data width on all three ports.
- MAX_PEND, 4, maximum outstanding reads; power of 2, at least 2; sets the ID FIFO depth.

Ports:
- clk_i input 1 clock; all logic on rising edge.
- rst_n_i input 1 async active-low reset.
- mN_address input ADDR_W, N=0,1: master N word address.
- mN_read input 1 master N read request.
- mN_write input 1 master N write request.
- mN_writedata input DATA_W master N write data.
- mN_waitrequest output 1 master N stall.
- mN_readdata output DATA_W master N read data.
- mN_readdatavalid output 1 master N read data valid.
- s_address output ADDR_W slave address.
- s_read output 1 slave read.
- s_write output 1 slave write.
- s_writedata output DATA_W slave write data.
- s_waitrequest input 1 slave stall.
- s_readdata input DATA_W slave read data.
- s_readdatavalid input 1 slave read data valid.
- err_o output 1 sticky protocol error flag.

Behaviour:
- Reset values: last_grant=1 (so m0 wins first contest), lock=0, FIFO empty (count=0), err_o=0, mN_readdatavalid=0.
- reqN = mN_read | mN_write. mN_read and mN_write both high in one cycle is illegal: treated as a write, err_o set.
- Grant, combinational from registers and request inputs:
  - If lock=1, grant=locked_id.
  - Else if only one reqN is high, grant goes to that master.
  - Else if both are high, grant = ~last_grant.
  - Else no grant.
- Slave outputs carry the granted master's address, read, write and writedata in the same cycle (zero added latency). With no grant, s_read=s_write=0 and s_address/s_writedata=0.
- full = (count==MAX_PEND).
- stall_g = s_waitrequest | (granted read & full). Granted master: mN_waitrequest=stall_g. Non-granted master: mN_waitrequest=1 whenever reqN=1, else 0.
- When full, s_read is suppressed (forced 0) for a granted read. Writes are never blocked by full.
- Accept = grant valid & !stall_g. On accept: last_grant<=grant, lock<=0.
- Grant valid & stall_g: lock<=1, locked_id<=grant. The grant holds until that command is accepted, keeping the command stable per Avalon rules.
- Accepted read: push grant ID into the FIFO.
- s_readdatavalid=1: pop the FIFO head ID. mID_readdatavalid<=1 and mID_readdata<=s_readdata, registered, so there is 1 cycle of added read latency. The other master's readdatavalid=0. mN_readdata holds its last value otherwise.
- Push and pop in the same cycle: count unchanged, both take effect. Push with full is impossible by construction.
- s_readdatavalid with empty FIFO: data dropped, err_o<=1. err_o clears only on reset.
- Count width is $clog2(MAX_PEND)+1; read and write pointers wrap modulo MAX_PEND.
- Reset mid-operation: the FIFO is flushed and in-flight read responses after reset raise err_o. The system must quiesce the slave before asserting reset.

Optional Feature:
- Macro: AMM_ARB_FIXED_PRIO_EN.
- Defined: the two-requester contest always grants m0; last_grant is still updated but ignored; the lock rule is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single master, 1-cycle-latency memory slave, s_waitrequest=0: m0 writes 0xA5A5 to addr 3, then reads addr 3. Required: m0_readdatavalid one cycle after s_readdatavalid with m0_readdata=0xA5A5; m1_readdatavalid stays 0.
- Both masters issue reads on every cycle for 8 cycles, starting in the cycle after reset. Required: grants go m0,m1,m0,... and each master receives exactly its own 4 reads, in order, with the correct data.
- Slave holds s_waitrequest=1 for 3 cycles while m1 is granted a write and m0 also requests. Required: s_address/s_write stay m1's for all 3 cycles; m0 is granted only after m1's write is accepted.
- Slave with latency 6 and MAX_PEND=4: m0 issues 6 back-to-back reads. Required: the 5th read sees m0_waitrequest=1 with s_read=0 until the first s_readdatavalid, then proceeds; no err_o.
- Inject s_readdatavalid with no outstanding read. Required: err_o=1 the next cycle and no mN_readdatavalid; assert rst_n_i low, err_o=0 asynchronously.
- With AMM_ARB_FIXED_PRIO_EN defined, repeat the both-masters-read-every-cycle test for 8 cycles. Required: m0 receives all grants and m1 waits until m0's requests stop.

Source files
------------

// File: rtl/amm_arb2.sv
// Two-master to one-slave Avalon-MM arbiter with round-robin grant and an ID FIFO that routes read responses.
// Optional build macro AMM_ARB_FIXED_PRIO_EN: m0 always wins a two-requester contest.
module amm_arb2 #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_o
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = $clog2(MAX_PEND) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

  logic req0, req1, rd0, rd1;
  logic gValid, gId, gRead, gWrite;
  logic full, stallG, accept, push, pop, drop, headId;

  logic              lastGrant_q, lastGrant_d;
  logic              lock_q, lock_d;
  logic              lockedId_q, lockedId_d;
  logic [MAX_PEND-1:0] idFifo_q, idFifo_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              rdv0_q, rdv0_d, rdv1_q, rdv1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // A read+write collision is treated as a write.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign rd0  = m0_read & ~m0_write;
  assign rd1  = m1_read & ~m1_write;

  always_comb begin
    gValid = 1'b0;
    gId    = 1'b0;
    if (lock_q) begin
      gValid = lockedId_q ? req1 : req0;
      gId    = lockedId_q;
    end else if (req0 && req1) begin
      gValid = 1'b1;
`ifdef AMM_ARB_FIXED_PRIO_EN
      gId    = 1'b0;
`else
      gId    = ~lastGrant_q;
`endif
    end else if (req0) begin
      gValid = 1'b1;
      gId    = 1'b0;
    end else if (req1) begin
      gValid = 1'b1;
      gId    = 1'b1;
    end
  end

  assign gRead  = gValid & (gId ? rd1 : rd0);
  assign gWrite = gValid & (gId ? m1_write : m0_write);
  assign full   = (count_q == FULL_CNT);
  assign stallG = s_waitrequest | (gRead & full);
  assign accept = gValid & ~stallG;
  assign push   = accept & gRead;
  assign pop    = s_readdatavalid & (count_q != '0);
  assign drop   = s_readdatavalid & (count_q == '0);
  assign headId = idFifo_q[rdPtr_q];

  assign s_read      = gRead & ~full;
  assign s_write     = gWrite;
  assign s_address   = gValid ? (gId ? m1_address : m0_address) : '0;
  assign s_writedata = gValid ? (gId ? m1_writedata : m0_writedata) : '0;

  assign m0_waitrequest = (gValid && !gId) ? stallG : req0;
  assign m1_waitrequest = (gValid &&  gId) ? stallG : req1;

  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign m0_readdata      = rdata0_q;
  assign m1_readdata      = rdata1_q;
  assign err_o            = err_q;

  // Lock keeps a stalled grant in place so the command stays stable until accepted.
  always_comb begin
    lastGrant_d = lastGrant_q;
    lock_d      = lock_q;
    lockedId_d  = lockedId_q;
    if (accept) begin
      lastGrant_d = gId;
      lock_d      = 1'b0;
    end else if (gValid) begin
      lock_d      = 1'b1;
      lockedId_d  = gId;
    end else begin
      lock_d      = 1'b0;
    end
  end

  always_comb begin
    idFifo_d = idFifo_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    if (push) begin
      idFifo_d[wrPtr_q] = gId;
      wrPtr_d           = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Responses are registered, adding one cycle of read latency.
  always_comb begin
    err_d    = err_q | drop | (m0_read & m0_write) | (m1_read & m1_write);
    rdv0_d   = pop & ~headId;
    rdv1_d   = pop &  headId;
    rdata0_d = rdv0_d ? s_readdata : rdata0_q;
    rdata1_d = rdv1_d ? s_readdata : rdata1_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lastGrant_q <= 1'b1;
      lock_q      <= 1'b0;
      lockedId_q  <= 1'b0;
      idFifo_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      rdv0_q      <= 1'b0;
      rdv1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      lock_q      <= lock_d;
      lockedId_q  <= lockedId_d;
      idFifo_q    <= idFifo_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      rdv0_q      <= rdv0_d;
      rdv1_q      <= rdv1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

endmodule
